uart_receiver: RTL
==================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving the data bits per frame (1..8).
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, giving the Tick pulses per bit period (even, 4..16).
REQ-003 The block SHALL have port Clock, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port Tick, input, 1 bit: baud-rate-generator pulse, one Clock cycle wide, at OVERSAMPLE x baud.
REQ-006 The block SHALL have port Rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port DataOut, output, DATA_BITS bits: last correctly received byte.
REQ-008 The block SHALL have port RxDone, output, 1 bit: one-cycle pulse, DataOut updated with a valid frame.
REQ-009 The block SHALL have port FrameError, output, 1 bit: one-cycle pulse, stop bit sampled low.

Function
REQ-010 Rx SHALL pass through a two-flop synchronizer; the state machine SHALL use only the synchronized value (RxS).
REQ-011 The state machine SHALL have states IDLE, START, DATA and STOP, with a tick counter (4 bits), a bit counter (3 bits) and a DATA_BITS shift register.
REQ-012 The tick counter SHALL advance only in cycles where Tick is high; Tick SHALL be ignored in IDLE.
REQ-013 IDLE SHALL go to START, clearing the tick counter, on a falling edge of RxS (previous 1, current 0); a level-low RxS without a preceding high SHALL NOT start a frame.
REQ-014 START SHALL, on the Tick where tick count equals OVERSAMPLE/2-1, go to DATA with both counters cleared if RxS is 0, or return to IDLE with no output activity if RxS is 1 (glitch rejection).
REQ-015 DATA SHALL, on the Tick where tick count equals OVERSAMPLE-1, shift RxS into the MSB of the shift register (LSB-first order) and clear the tick counter.
REQ-016 On that DATA sample, if the bit count equals DATA_BITS-1 the state SHALL become STOP; otherwise the bit count SHALL increment.
REQ-017 STOP SHALL, on the Tick where tick count equals OVERSAMPLE-1, sample RxS and return to IDLE.
REQ-018 If the STOP sample is 1, the shift register SHALL be loaded into DataOut and RxDone SHALL pulse high for exactly one Clock cycle.
REQ-019 If the STOP sample is 0, FrameError SHALL pulse for one cycle, DataOut SHALL hold its old value, and RxDone SHALL stay low.
REQ-020 RxDone and FrameError SHALL be registered outputs and SHALL never be high in the same cycle.
REQ-021 With OVERSAMPLE=16, RxDone SHALL occur on the 8+16*(DATA_BITS+1)-th Tick after start-edge detection (152 Ticks for 8 bits).
REQ-022 DataOut SHALL be overwritten on every valid frame with no overrun protection; it SHALL be stable between RxDone pulses.
REQ-023 A start edge arriving in the same cycle as the STOP-to-IDLE transition SHALL be detected in the next cycle, so that back-to-back frames are received.
REQ-024 Unused state encodings SHALL transition to IDLE.

Reset
REQ-025 While Reset is high, the state SHALL be IDLE, the counters and shift register SHALL be 0, the synchronizer flops and previous-RxS SHALL be 1, DataOut SHALL be 0, and RxDone and FrameError SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame immediately with no RxDone or FrameError pulse; reception SHALL resume with the next falling edge after Reset deasserts.

Verification
REQ-027 Reset scenario: with Reset high and Rx toggling, DataOut, RxDone and FrameError SHALL all read 0 and no pulse SHALL occur.
REQ-028 Single-frame scenario: with Tick every 4 Clocks, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1); there SHALL be exactly one RxDone pulse, DataOut=8'hA5, FrameError=0, and RxDone at Tick 152 after the start edge.
REQ-029 Glitch scenario: drive Rx low for 3 Ticks then high; there SHALL be no RxDone and no FrameError, and the block SHALL be back in IDLE by Tick 8.
REQ-030 Framing-error scenario: send 0x3C with stop=0 and hold Rx low for 20 bit periods; there SHALL be exactly one FrameError pulse, DataOut SHALL remain 8'hA5, and no new frame SHALL start until Rx returns high.
REQ-031 Back-to-back scenario: send 0x00 then 0xFF with no idle gap; there SHALL be two RxDone pulses, with DataOut=8'h00 then 8'hFF.
REQ-032 Mid-frame reset scenario: assert Reset during data bit 3 of 0x55; there SHALL be no pulse, and a following 0x3C SHALL yield RxDone with DataOut=8'h3C.

Source files
------------

// File: rtl/uart_receiver.sv
// Oversampled UART receiver: start-bit glitch rejection, LSB-first data capture,
// stop-bit check with one-cycle RxDone / FrameError pulses, receive state on DebugState.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Tick,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] DataOut,
    output logic                 RxDone,
    output logic                 FrameError,
    output logic [1:0]           DebugState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } RxStateT;

    localparam logic [3:0] TICK_HALF = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    RxStateT              state;
    RxStateT              stateNext;
    logic                 rxMeta;
    logic                 rxS;
    logic                 rxPrev;
    logic                 fallEdge;
    logic [3:0]           tickCnt;
    logic [3:0]           tickNext;
    logic [2:0]           bitCnt;
    logic [2:0]           bitNext;
    logic [DATA_BITS-1:0] shiftReg;
    logic [DATA_BITS-1:0] shiftNext;
    logic [DATA_BITS-1:0] shiftIn;
    logic                 stopSample;

    assign fallEdge   = rxPrev & ~rxS;
    assign DebugState = state;

    generate
        if (DATA_BITS == 1) begin : gShiftOne
            assign shiftIn = rxS;
        end else begin : gShiftMany
            assign shiftIn = {rxS, shiftReg[DATA_BITS-1:1]};
        end
    endgenerate

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        tickNext   = tickCnt;
        bitNext    = bitCnt;
        shiftNext  = shiftReg;
        stopSample = 1'b0;
        case (state)
            IDLE: begin
                if (fallEdge) begin
                    stateNext = START;
                    tickNext  = '0;
                end
            end
            START: begin
                if (Tick) begin
                    if (tickCnt == TICK_HALF) begin
                        if (!rxS) begin
                            stateNext = DATA;
                            tickNext  = '0;
                            bitNext   = '0;
                        end else begin
                            stateNext = IDLE;
                        end
                    end else begin
                        tickNext = tickCnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (Tick) begin
                    if (tickCnt == TICK_LAST) begin
                        shiftNext = shiftIn;
                        tickNext  = '0;
                        if (bitCnt == BIT_LAST) begin
                            stateNext = STOP;
                        end else begin
                            bitNext = bitCnt + 3'd1;
                        end
                    end else begin
                        tickNext = tickCnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (Tick) begin
                    if (tickCnt == TICK_LAST) begin
                        stopSample = 1'b1;
                        stateNext  = IDLE;
                        tickNext   = '0;
                    end else begin
                        tickNext = tickCnt + 4'd1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rxMeta     <= 1'b1;
            rxS        <= 1'b1;
            rxPrev     <= 1'b1;
            tickCnt    <= '0;
            bitCnt     <= '0;
            shiftReg   <= '0;
            DataOut    <= '0;
            RxDone     <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            rxMeta   <= Rx;
            rxS      <= rxMeta;
            // An edge seen while leaving STOP is held over so IDLE still catches it next cycle.
            rxPrev   <= (stopSample && fallEdge) ? 1'b1 : rxS;
            tickCnt  <= tickNext;
            bitCnt   <= bitNext;
            shiftReg <= shiftNext;
            RxDone     <= stopSample & rxS;
            FrameError <= stopSample & ~rxS;
            if (stopSample && rxS) begin
                DataOut <= shiftReg;
            end
        end
    end

endmodule
